// File: rtl/wb_nic_fabric_pkg.sv
// Shared types and defaults for the Wishbone slave-select fabric.
package nic_pkg;

    typedef enum logic [1:0] {
        NIC_IDLE = 2'd0,
        NIC_BUSY = 2'd1,
        NIC_RESP = 2'd2
    } nic_state_t;

    localparam int SLAVE_SEL_WIDTH = 4;
    localparam int WB_ADR_WIDTH    = 32;

endpackage

// File: rtl/wb_nic_fabric_if.sv
// Master-side Wishbone bus between the core and the slave-select fabric.
interface wb_nic_fabric_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           adr;
    logic                  cyc;
    logic                  stb;
    logic [DATA_WIDTH-1:0] dat;
    logic                  ack;
    logic                  err;

    modport master (output adr, cyc, stb, input dat, ack, err);
    modport slave  (input adr, cyc, stb, output dat, ack, err);
endinterface

// File: rtl/wb_nic_fabric_wdt.sv
// Clear/enable watchdog counter with terminal-count flag; saturates at MAX_COUNT-1.
module nic_wdt #(
    parameter int MAX_COUNT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] cnt_one_c = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] tc_val_c  = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count enabled cycles; hold at terminal count so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && !tc) begin
            cnt_r <= cnt_r + cnt_one_c;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == tc_val_c);
endmodule

// File: rtl/wb_nic_fabric.sv
// Registered Wishbone slave-select fabric: address decode, one-hot select, response return,
// unmapped/timeout error responses and sticky error-address capture.
module wb_nic_fabric
    import nic_pkg::*;
#(
    parameter int ADDR_SEL_WIDTH = SLAVE_SEL_WIDTH,
    parameter int SEL_LSB        = 28,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [(2**ADDR_SEL_WIDTH)-1:0] SLAVE_MASK = 16'h0003
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset_n,
    wb_nic_fabric_if.slave                                wb,
    output logic [(2**ADDR_SEL_WIDTH)-1:0]                o_slave_sel,
    input  logic [(2**ADDR_SEL_WIDTH)-1:0][DATA_WIDTH-1:0] i_slave_rdata,
    input  logic [(2**ADDR_SEL_WIDTH)-1:0]                i_slave_ack,
    output logic                                          o_err_flag,
    output logic [WB_ADR_WIDTH-1:0]                       o_err_addr,
    input  logic                                          i_err_clr
);
    localparam int N = 2**ADDR_SEL_WIDTH;
    localparam logic [N-1:0] sel_one_c = {{(N-1){1'b0}}, 1'b1};

    nic_state_t                state_r;
    logic [ADDR_SEL_WIDTH-1:0] idx_s;
    logic [ADDR_SEL_WIDTH-1:0] idx_r;
    logic [WB_ADR_WIDTH-1:0]   adr_r;
    logic [DATA_WIDTH-1:0]     dat_r;
    logic                      ack_r;
    logic                      err_r;
    logic [N-1:0]              sel_r;
    logic                      err_flag_r;
    logic [WB_ADR_WIDTH-1:0]   err_addr_r;
    logic                      req_s;
    logic                      tc_s;

    assign idx_s = wb.adr[SEL_LSB +: ADDR_SEL_WIDTH];
    assign req_s = wb.cyc && wb.stb;

    // Watchdog only runs while a mapped slave is selected; any other state restarts it.
    nic_wdt #(.MAX_COUNT(TIMEOUT_CYCLES)) u_wdt (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .clr     (state_r != NIC_BUSY),
        .en      (state_r == NIC_BUSY),
        .tc      (tc_s)
    );

    // Transfer FSM; responses are one-cycle pulses owned by RESP, error capture set beats clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r    <= NIC_IDLE;
            idx_r      <= '0;
            adr_r      <= '0;
            dat_r      <= '0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            sel_r      <= '0;
            err_flag_r <= 1'b0;
            err_addr_r <= '0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            if (i_err_clr) begin
                err_flag_r <= 1'b0;
            end
            case (state_r)
                NIC_IDLE: begin
                    sel_r <= '0;
                    if (req_s) begin
                        idx_r <= idx_s;
                        adr_r <= wb.adr;
                        if (SLAVE_MASK[idx_s]) begin
                            state_r <= NIC_BUSY;
                            sel_r   <= sel_one_c << idx_s;
                        end else begin
                            state_r    <= NIC_RESP;
                            err_r      <= 1'b1;
                            err_flag_r <= 1'b1;
                            err_addr_r <= wb.adr;
                        end
                    end else begin
                        state_r <= NIC_IDLE;
                    end
                end
                NIC_BUSY: begin
                    if (!wb.cyc) begin
                        state_r <= NIC_IDLE;
                        sel_r   <= '0;
                    end else if (i_slave_ack[idx_r]) begin
                        state_r <= NIC_RESP;
                        sel_r   <= '0;
                        ack_r   <= 1'b1;
                        dat_r   <= i_slave_rdata[idx_r];
                    end else if (tc_s) begin
                        state_r    <= NIC_RESP;
                        sel_r      <= '0;
                        err_r      <= 1'b1;
                        err_flag_r <= 1'b1;
                        err_addr_r <= adr_r;
                    end else begin
                        state_r <= NIC_BUSY;
                    end
                end
                NIC_RESP: begin
                    state_r <= NIC_IDLE;
                    sel_r   <= '0;
                end
                default: begin
                    state_r <= NIC_IDLE;
                    sel_r   <= '0;
                end
            endcase
        end
    end

    assign wb.dat      = dat_r;
    assign wb.ack      = ack_r;
    assign wb.err      = err_r;
    assign o_slave_sel = sel_r;
    assign o_err_flag  = err_flag_r;
    assign o_err_addr  = err_addr_r;
endmodule

// File: tb/tb_wb_nic_fabric.sv
// Self-checking bench for wb_nic_fabric: directed corner cases then randomized transfers
// against a transaction-level model of the expected response timing and error capture.
module tb_wb_nic_fabric;
    import nic_pkg::*;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [N-1:0] MASK = 16'h0003;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   err_clr = 1'b0;
    logic [N-1:0]           slave_sel;
    logic [N-1:0][DW-1:0]   slave_rdata = '0;
    logic [N-1:0]           slave_ack = '0;
    logic                   err_flag;
    logic [31:0]            err_addr;

    wb_nic_fabric_if #(.DATA_WIDTH(DW)) wb ();

    int tests  = 0;
    int failed = 0;

    logic [31:0] m_dat      = 32'h0;
    logic        m_err_flag = 1'b0;
    logic [31:0] m_err_addr = 32'h0;

    always #5 clk = ~clk;

    wb_nic_fabric #(
        .ADDR_SEL_WIDTH (4),
        .SEL_LSB        (28),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .SLAVE_MASK     (MASK)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .wb            (wb),
        .o_slave_sel   (slave_sel),
        .i_slave_rdata (slave_rdata),
        .i_slave_ack   (slave_ack),
        .o_err_flag    (err_flag),
        .o_err_addr    (err_addr),
        .i_err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic ack_e, input logic err_e,
                                 input logic [N-1:0] sel_e);
        check({tag, ".ack"},      {63'h0, wb.ack},   {63'h0, ack_e});
        check({tag, ".err"},      {63'h0, wb.err},   {63'h0, err_e});
        check({tag, ".sel"},      64'(slave_sel),    64'(sel_e));
        check({tag, ".dat"},      64'(wb.dat),       64'(m_dat));
        check({tag, ".err_flag"}, {63'h0, err_flag}, {63'h0, m_err_flag});
        check({tag, ".err_addr"}, 64'(err_addr),     64'(m_err_addr));
    endtask

    // One master transfer; delay = sel cycles before the slave acks (>= TO means never in time).
    task automatic run_txn(input string tag, input logic [31:0] adr, input int delay,
                           input logic [31:0] rdata, input bit clr_at_req);
        int           idx;
        bit           mapped;
        bit           is_ack;
        int           resp;
        logic [N-1:0] onehot;
        idx    = int'(adr[31:28]);
        mapped = MASK[idx];
        is_ack = mapped && (delay < TO);
        resp   = !mapped ? 1 : (is_ack ? delay + 2 : TO + 1);
        onehot = '0;
        onehot[idx] = 1'b1;
        wb.adr  = adr;
        wb.cyc  = 1'b1;
        wb.stb  = 1'b1;
        err_clr = clr_at_req;
        for (int c = 1; c <= resp; c++) begin
            tick();
            err_clr = 1'b0;
            if (c == 1 && clr_at_req) m_err_flag = 1'b0;
            if (c == resp) begin
                if (is_ack) begin
                    m_dat = rdata;
                end else begin
                    m_err_flag = 1'b1;
                    m_err_addr = adr;
                end
            end
            check_outputs(tag, (c == resp) && is_ack, (c == resp) && !is_ack,
                          (mapped && c < resp) ? onehot : '0);
            wb.stb = 1'($urandom_range(0, 1));
            for (int s = 0; s < N; s++) slave_rdata[s] = $urandom;
            slave_ack = N'($urandom) & ~onehot;
            if (mapped && (c - 1 == delay) && c < resp) begin
                slave_ack[idx]   = 1'b1;
                slave_rdata[idx] = rdata;
            end
            if (c == resp) begin
                wb.cyc    = 1'b0;
                wb.stb    = 1'b0;
                slave_ack = '0;
            end
        end
        tick();
        check_outputs({tag, ".after"}, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [31:0] adr;
        int          pick;
        wb.adr = 32'h0;
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        tick();
        tick();
        check_outputs("reset", 1'b0, 1'b0, '0);
        reset_n = 1'b1;
        tick();

        run_txn("read_s1",      32'h1000_0004, 0,   32'hDEAD_BEEF, 1'b0);
        run_txn("unmapped",     32'h5000_0000, 0,   32'h0,         1'b0);
        run_txn("timeout",      32'h1000_0000, 100, 32'h1234_5678, 1'b0);
        run_txn("ack_on_tc",    32'h1000_0008, TO - 1, 32'hCAFE_F00D, 1'b0);
        run_txn("clr_vs_set",   32'h7000_0000, 0,   32'h0,         1'b1);

        err_clr = 1'b1;
        tick();
        err_clr    = 1'b0;
        m_err_flag = 1'b0;
        check_outputs("clr_alone", 1'b0, 1'b0, '0);

        // Abort: cyc dropped while the slave is still selected.
        wb.adr = 32'h0000_0010;
        wb.cyc = 1'b1;
        wb.stb = 1'b1;
        tick();
        check_outputs("abort.busy1", 1'b0, 1'b0, 16'h0001);
        wb.stb = 1'b0;
        tick();
        check_outputs("abort.busy2", 1'b0, 1'b0, 16'h0001);
        wb.cyc = 1'b0;
        tick();
        check_outputs("abort.idle1", 1'b0, 1'b0, '0);
        tick();
        check_outputs("abort.idle2", 1'b0, 1'b0, '0);

        // Reset while a second transfer is in BUSY.
        wb.adr = 32'h1000_0000;
        wb.cyc = 1'b1;
        wb.stb = 1'b1;
        tick();
        check_outputs("rst_mid.busy", 1'b0, 1'b0, 16'h0002);
        reset_n = 1'b0;
        wb.cyc  = 1'b0;
        wb.stb  = 1'b0;
        tick();
        m_dat      = 32'h0;
        m_err_flag = 1'b0;
        m_err_addr = 32'h0;
        check_outputs("rst_mid.reset", 1'b0, 1'b0, '0);
        reset_n = 1'b1;
        tick();
        check_outputs("rst_mid.idle", 1'b0, 1'b0, '0);

        run_txn("post_rst_to", 32'h0000_0020, 100, 32'h0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            pick = int'($urandom_range(0, 3));
            adr  = $urandom;
            if (pick == 0) adr[31:28] = 4'h0;
            else if (pick == 1) adr[31:28] = 4'h1;
            run_txn("rand", adr, int'($urandom_range(0, TO + 1)), $urandom,
                    ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
